reset_monitor: RTL and testbench

- Receiving end of the periodic active-low reset request produced by the board reset generator.
- Synchronises the request into clk_100, rejects glitches shorter than MIN_LOW cycles, and drives a clean reset to a downstream block.
- After release, waits for that block's init_done handshake with a timeout.
- Measures each accepted pulse's low width and the preceding high period, and keeps sticky error flags for the camera/SDRAM bring-up debug path.

---
 rtl/reset_monitor.sv | 149 ++++++++++++++
 tb/tb_reset_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_monitor.sv
// Reset request receiver: synchronises and glitch-filters the board reset request,
// drives a clean reset downstream, waits for init_done and records pulse statistics.
module reset_monitor #(
    parameter int unsigned MIN_LOW      = 16,
    parameter int unsigned INIT_TIMEOUT = 1_000_000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk_100,
    input  logic             rst_n,
    input  logic             rst_req_in,
    input  logic             init_done,
    input  logic             clr_err,
    output logic             sys_rst_n,
    output logic             rst_busy,
    output logic [CNT_W-1:0] low_width,
    output logic [CNT_W-1:0] high_period,
    output logic [15:0]      pulse_cnt,
    output logic [15:0]      glitch_cnt,
    output logic             meas_vld,
    output logic             err_glitch,
    output logic             err_timeout
);

    localparam int unsigned      FLT_W    = $clog2(MIN_LOW + 1);
    localparam int unsigned      TO_W     = $clog2(INIT_TIMEOUT + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(MIN_LOW - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LO_START = CNT_W'(MIN_LOW);

    typedef enum logic [1:0] {
        RUN,
        FILT,
        RESET,
        WAIT_INIT
    } state_t;

    state_t           state;
    logic             req_meta;
    logic             req_s;
    logic [FLT_W-1:0] flt_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] lo_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Synchroniser resets to the idle (high) level so reset release never looks like a request
    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            req_meta <= 1'b1;
            req_s    <= 1'b1;
        end else begin
            req_meta <= rst_req_in;
            req_s    <= req_meta;
        end
    end

    always_ff @(posedge clk_100) begin
        if (!rst_n) begin
            state       <= RESET;
            sys_rst_n   <= 1'b0;
            rst_busy    <= 1'b1;
            flt_cnt     <= '0;
            to_cnt      <= '0;
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            low_width   <= '0;
            high_period <= '0;
            pulse_cnt   <= '0;
            glitch_cnt  <= '0;
            meas_vld    <= 1'b0;
            err_glitch  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            meas_vld <= 1'b0;
            // Later set assignments below override this clear in the same cycle
            if (clr_err) begin
                err_glitch  <= 1'b0;
                err_timeout <= 1'b0;
            end
            case (state)
                RUN: begin
                    hi_cnt <= sat_inc(hi_cnt);
                    if (!req_s) begin
                        state   <= FILT;
                        flt_cnt <= FLT_W'(1);
                    end
                end
                FILT: begin
                    hi_cnt <= sat_inc(hi_cnt);
                    if (req_s) begin
                        state      <= RUN;
                        glitch_cnt <= sat_inc16(glitch_cnt);
                        err_glitch <= 1'b1;
                    end else if (flt_cnt == FLT_LAST) begin
                        state       <= RESET;
                        sys_rst_n   <= 1'b0;
                        rst_busy    <= 1'b1;
                        high_period <= hi_cnt;
                        lo_cnt      <= LO_START;
                    end else begin
                        flt_cnt <= flt_cnt + 1'b1;
                    end
                end
                RESET: begin
                    if (req_s) begin
                        state     <= WAIT_INIT;
                        sys_rst_n <= 1'b1;
                        to_cnt    <= '0;
                        hi_cnt    <= CNT_W'(1);
                        // lo_cnt is zero only when leaving the power-on reset
                        if (lo_cnt != '0) begin
                            low_width <= lo_cnt;
                            pulse_cnt <= sat_inc16(pulse_cnt);
                        end
                    end else begin
                        lo_cnt <= sat_inc(lo_cnt);
                    end
                end
                WAIT_INIT: begin
                    hi_cnt <= sat_inc(hi_cnt);
                    to_cnt <= to_cnt + 1'b1;
                    if (!req_s) begin
                        state    <= FILT;
                        flt_cnt  <= FLT_W'(1);
                        rst_busy <= 1'b0;
                    end else if (init_done) begin
                        state    <= RUN;
                        rst_busy <= 1'b0;
                        meas_vld <= 1'b1;
                    end else if (to_cnt == TO_LAST) begin
                        state       <= RUN;
                        rst_busy    <= 1'b0;
                        err_timeout <= 1'b1;
                        meas_vld    <= 1'b1;
                    end
                end
                default: state <= RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_reset_monitor.sv
// Randomised bench for reset_monitor: an episode-level timing model feeds scoreboards
// that a negedge monitor drains on meas_vld and on sys_rst_n transitions.
module tb_reset_monitor;

    localparam int MIN_LOW = 4;
    localparam int TO      = 50;
    localparam int CNT_W   = 32;
    localparam int NEVER   = 1 << 30;

    logic             clk_100 = 1'b0;
    logic             rst_n;
    logic             rst_req_in;
    logic             init_done;
    logic             clr_err;
    logic             sys_rst_n;
    logic             rst_busy;
    logic [CNT_W-1:0] low_width;
    logic [CNT_W-1:0] high_period;
    logic [15:0]      pulse_cnt;
    logic [15:0]      glitch_cnt;
    logic             meas_vld;
    logic             err_glitch;
    logic             err_timeout;

    reset_monitor #(.MIN_LOW(MIN_LOW), .INIT_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk_100(clk_100), .rst_n(rst_n), .rst_req_in(rst_req_in), .init_done(init_done),
        .clr_err(clr_err), .sys_rst_n(sys_rst_n), .rst_busy(rst_busy), .low_width(low_width),
        .high_period(high_period), .pulse_cnt(pulse_cnt), .glitch_cnt(glitch_cnt),
        .meas_vld(meas_vld), .err_glitch(err_glitch), .err_timeout(err_timeout)
    );

    always #5 clk_100 = ~clk_100;

    int cyc = 0;
    always @(posedge clk_100) cyc <= cyc + 1;

    typedef struct { int at; int lw; int hp; int pc; int to; } meas_t;
    typedef struct { int fall; int rise; } win_t;
    meas_t meas_q[$];
    win_t  win_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    // Episode-level model state, all in absolute edge numbers
    int last_rel;
    int pulses      = 0;
    int glitches    = 0;
    int clr_edge    = 0;
    int to_edge     = -1;
    int glitch_edge = -1;
    bit mon_en      = 1'b0;
    logic prev_sys  = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_100);
        #1;
    endtask

    always @(negedge clk_100) begin : monitor
        meas_t m;
        win_t  w;
        if (mon_en) begin
            if (meas_vld) begin
                if (meas_q.size() == 0) check("meas_vld_unexpected", 1, 0);
                else begin
                    m = meas_q.pop_front();
                    check("meas_edge", cyc, m.at);
                    check("low_width", low_width, m.lw);
                    check("high_period", high_period, m.hp);
                    check("meas_pulse_cnt", pulse_cnt, m.pc);
                    check("meas_err_timeout", err_timeout, m.to);
                end
            end
            if (prev_sys === 1'b1 && sys_rst_n === 1'b0) begin
                if (win_q.size() == 0) check("sys_rst_fall_unexpected", 1, 0);
                else check("sys_rst_fall_edge", cyc, win_q[0].fall);
            end
            if (prev_sys === 1'b0 && sys_rst_n === 1'b1) begin
                if (win_q.size() == 0) check("sys_rst_rise_unexpected", 1, 0);
                else begin
                    w = win_q.pop_front();
                    check("sys_rst_rise_edge", cyc, w.rise);
                end
            end
        end
        prev_sys = sys_rst_n;
    end

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Input low for l cycles (with a clr_err pulse on the first), then high for h cycles;
    // init_done rises d cycles after the input rises if that lies inside the high phase.
    task automatic episode(input int l, input int d, input int h);
        int f, r, a, rel, done_at, exit_at, next_low;
        bit timeout, to_exp;
        f        = cyc + 1;
        r        = f + l;
        next_low = r + h + 2;
        clr_edge = f;
        if (l >= MIN_LOW) begin
            a   = f + 2 + MIN_LOW - 1;
            rel = r + 2;
            pulses++;
            win_q.push_back('{a, rel});
            done_at = NEVER;
            if (d < h && imax(r + d, rel + 1) <= r + h - 1) done_at = imax(r + d, rel + 1);
            timeout = (done_at - rel > TO);
            exit_at = timeout ? rel + TO : done_at;
            if (next_low > exit_at) begin
                to_exp = timeout || (to_edge >= clr_edge);
                meas_q.push_back('{exit_at, l, a - last_rel, pulses, int'(to_exp)});
                if (timeout) to_edge = exit_at;
            end
            last_rel = rel;
        end else begin
            glitches++;
            glitch_edge = r + 2;
        end
        rst_req_in = 1'b0;
        init_done  = 1'b0;
        clr_err    = 1'b1;
        step();
        clr_err = 1'b0;
        for (int i = 1; i < l; i++) step();
        rst_req_in = 1'b1;
        for (int j = 0; j < h; j++) begin
            if (j == d) init_done = 1'b1;
            step();
        end
        if (h >= 3) begin
            check("pulse_cnt", pulse_cnt, pulses);
            check("glitch_cnt", glitch_cnt, glitches);
            check("err_glitch", err_glitch, (glitch_edge >= clr_edge && glitch_edge <= cyc));
            check("err_timeout", err_timeout, (to_edge >= clr_edge && to_edge <= cyc));
        end
    endtask

    task automatic clear_errors();
        clr_edge = cyc + 1;
        clr_err  = 1'b1;
        step();
        clr_err = 1'b0;
        step();
        check("err_glitch_cleared", err_glitch, (glitch_edge >= clr_edge));
        check("err_timeout_cleared", err_timeout, (to_edge >= clr_edge));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sys_rst_n"}, sys_rst_n, 0);
        check({tag, "_rst_busy"}, rst_busy, 1);
        check({tag, "_low_width"}, low_width, 0);
        check({tag, "_high_period"}, high_period, 0);
        check({tag, "_pulse_cnt"}, pulse_cnt, 0);
        check({tag, "_glitch_cnt"}, glitch_cnt, 0);
        check({tag, "_meas_vld"}, meas_vld, 0);
        check({tag, "_err_glitch"}, err_glitch, 0);
        check({tag, "_err_timeout"}, err_timeout, 0);
    endtask

    task automatic release_reset(input int done_delay);
        rst_n    = 1'b1;
        last_rel = cyc + 1;
        win_q.push_back('{-1, last_rel});
        meas_q.push_back('{last_rel + done_delay, 0, 0, 0, 0});
        mon_en = 1'b1;
        for (int j = 0; j < done_delay + 5; j++) begin
            if (j == done_delay) init_done = 1'b1;
            step();
            if (j == 1) begin
                check("por_sys_rst_n_released", sys_rst_n, 1);
                check("por_rst_busy_wait", rst_busy, 1);
            end
        end
        check("por_rst_busy_run", rst_busy, 0);
        check("por_pulse_cnt", pulse_cnt, 0);
    endtask

    initial begin
        int f;
        rst_n      = 1'b0;
        rst_req_in = 1'b1;
        init_done  = 1'b0;
        clr_err    = 1'b0;
        repeat (3) step();
        check_reset_values("por");
        release_reset(5);

        episode(3, 0, 20);
        clear_errors();
        repeat (178) step();
        episode(20, 12, 100);
        episode(8, 1000, 80);
        episode(6, 1000, 10);
        episode(5, 3, 60);

        for (int k = 0; k < 30; k++)
            episode($urandom_range(1, 12), $urandom_range(0, 70), $urandom_range(1, 90));
        repeat (100) step();

        // Synchronous reset in the middle of an accepted pulse
        mon_en     = 1'b0;
        f          = cyc + 1;
        rst_req_in = 1'b0;
        init_done  = 1'b0;
        while (cyc < f + 11) step();
        check("mid_reset_sys_rst_n", sys_rst_n, 0);
        rst_n = 1'b0;
        step();
        check_reset_values("mid");
        rst_req_in = 1'b1;
        repeat (3) step();
        meas_q.delete();
        win_q.delete();
        pulses   = 0;
        glitches = 0;
        release_reset(3);
        repeat (10) step();

        check("meas_queue_drained", meas_q.size(), 0);
        check("win_queue_drained", win_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
